// File: rtl/wb_arbiter.sv
// Write-back arbiter in front of the register file write port.
// Merges the in-order MEM/WB result stream with out-of-order mul/div results. Mul/div results
// are buffered in a small circular FIFO and drain only on cycles with no valid pipeline write.
// A pending-destination scoreboard tracks issued mul/div ops for ID-stage hazard checks.
//
// Ports:
//   clock, resetn              clock; synchronous active-low reset
//   p_we, p_wn, p_d            MEM/WB write (never stalled)
//   m_valid, m_wn, m_d, m_ready  mul/div result handshake into the FIFO
//   issue_valid, issue_wn      mul/div op issue; sets the pending bit
//   rna, rnb, pend_a, pend_b   ID-stage source lookups into the scoreboard
//   wb_we, wb_wn, wb_d         registered register file write port
module wb_arbiter #(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned AW    = 1
) (
  input  logic        clock,
  input  logic        resetn,
  input  logic        p_we,
  input  logic [4:0]  p_wn,
  input  logic [31:0] p_d,
  input  logic        m_valid,
  input  logic [4:0]  m_wn,
  input  logic [31:0] m_d,
  output logic        m_ready,
  input  logic        issue_valid,
  input  logic [4:0]  issue_wn,
  input  logic [4:0]  rna,
  input  logic [4:0]  rnb,
  output logic        pend_a,
  output logic        pend_b,
  output logic        wb_we,
  output logic [4:0]  wb_wn,
  output logic [31:0] wb_d
);

  localparam int unsigned CW = AW + 1;
  localparam logic [AW:0] FullCnt = CW'(DEPTH);

  logic [4:0]  fifo_wn_q [DEPTH];
  logic [31:0] fifo_d_q  [DEPTH];

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  // Bit 0 is kept in the vector so rna/rnb == 0 index a constant zero.
  logic [31:0]   pending_q, pending_d;
  logic          wb_we_q, wb_we_d;
  logic [4:0]    wb_wn_q, wb_wn_d;
  logic [31:0]   wb_d_q, wb_d_d;

  logic        p_valid;
  logic        push;
  logic        store;
  logic        pop;
  logic [4:0]  head_wn;
  logic [31:0] head_d;

  // Ready depends only on registered occupancy: a same-cycle pop never frees a full FIFO.
  assign m_ready = resetn & (count_q != FullCnt);

  assign p_valid = p_we & (p_wn != 5'd0);
  assign push    = m_valid & m_ready;
  // Results for r0 complete the handshake but are never stored.
  assign store   = push & (m_wn != 5'd0);
  assign pop     = ~p_valid & (count_q != '0);
  assign head_wn = fifo_wn_q[rd_ptr_q];
  assign head_d  = fifo_d_q[rd_ptr_q];

  assign pend_a = resetn & pending_q[rna];
  assign pend_b = resetn & pending_q[rnb];

  assign wb_we = wb_we_q;
  assign wb_wn = wb_wn_q;
  assign wb_d  = wb_d_q;

  always_comb begin
    wb_we_d   = 1'b0;
    wb_wn_d   = wb_wn_q;
    wb_d_d    = wb_d_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    pending_d = pending_q;

    if (p_valid) begin
      wb_we_d = 1'b1;
      wb_wn_d = p_wn;
      wb_d_d  = p_d;
    end else if (pop) begin
      wb_we_d = 1'b1;
      wb_wn_d = head_wn;
      wb_d_d  = head_d;
    end

    if (store) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)   rd_ptr_d = rd_ptr_q + 1'b1;

    unique case ({store, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase

    // Clear first so a same-cycle issue to the same register wins.
    if (pop) pending_d[head_wn] = 1'b0;
    if (issue_valid && (issue_wn != 5'd0)) pending_d[issue_wn] = 1'b1;
    pending_d[0] = 1'b0;
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      wb_we_q   <= 1'b0;
      wb_wn_q   <= 5'd0;
      wb_d_q    <= 32'd0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      pending_q <= 32'd0;
    end else begin
      wb_we_q   <= wb_we_d;
      wb_wn_q   <= wb_wn_d;
      wb_d_q    <= wb_d_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      pending_q <= pending_d;
    end
  end

  // Storage needs no reset: occupancy gates every read.
  always_ff @(posedge clock) begin
    if (store) begin
      fifo_wn_q[wr_ptr_q] <= m_wn;
      fifo_d_q[wr_ptr_q]  <= m_d;
    end
  end

endmodule

// File: doc/wb_arbiter.md
# wb_arbiter

Write-back arbiter sitting directly upstream of the register file write port (`we`, `wn`, `d`) in the pipelined computer. It merges the in-order MEM/WB result stream with out-of-order results from the multi-cycle mul/div unit, buffering the latter in a small FIFO. It also keeps a pending-destination scoreboard that the ID-stage hazard logic queries for both source operands.

## Interface
Parameters:
- `DEPTH`, 2: mul/div result FIFO entries, power of two, ≥2.
- `AW`, 1: FIFO pointer width, log2(DEPTH).

Ports:
- `clock`  in  1  system clock; all state updates on posedge.
- `resetn`  in  1  synchronous active-low reset (sampled on posedge clock).
- `p_we`  in  1  MEM/WB write enable; never stalled by this block.
- `p_wn`  in  5  MEM/WB destination register.
- `p_d`  in  32  MEM/WB result.
- `m_valid`  in  1  mul/div result valid.
- `m_wn`  in  5  mul/div destination register.
- `m_d`  in  32  mul/div result.
- `m_ready`  out  1  FIFO can accept; transfer when `m_valid & m_ready`.
- `issue_valid`  in  1  mul/div op issued this cycle.
- `issue_wn`  in  5  destination of issued op.
- `rna`, `rnb`  in  5 each  ID-stage source register numbers.
- `pend_a`, `pend_b`  out  1 each  source has an outstanding mul/div write.
- `wb_we`  out  1  register file write enable (to `we`).
- `wb_wn`  out  5  register file write address (to `wn`).
- `wb_d`  out  32  register file write data (to `d`).

## Operation
- Pipeline path has absolute priority; the FIFO drains only on cycles without a valid pipeline write.
- Pipeline write is valid when `p_we==1` and `p_wn!=0`. A write with `p_wn==0` is dropped and the slot is treated as free.
- Output register, each posedge:
  - valid pipeline write → `wb_we=1`, `wb_wn=p_wn`, `wb_d=p_d`;
  - else FIFO non-empty → pop head, `wb_we=1`, `wb_wn/wb_d` = head;
  - else `wb_we=0`, `wb_wn`/`wb_d` hold their previous values.
- FIFO: circular buffer of {wn, d}. `wr_ptr`/`rd_ptr` are AW bits and wrap modulo DEPTH. Occupancy counter is 0..DEPTH.
  - Push when `m_valid & m_ready`. A push with `m_wn==0` is accepted and discarded (not stored).
- `m_ready = resetn & (count != DEPTH)`, combinational from the registered count only. When full, `m_ready=0` even if a pop occurs that cycle.
- Simultaneous push and pop: count unchanged, both pointers advance.
- No FIFO bypass: a mul/div result always spends at least one cycle in the FIFO.
- Scoreboard `pending[31:1]`, each posedge:
  - set bit `issue_wn` when `issue_valid & issue_wn!=0`;
  - clear bit `wb_wn_next` when a FIFO pop is driven to the output.
  - Same bit set and cleared in one cycle: set wins (a newer op targets it).
  - Bit 0 is constant 0.
- `pend_a = pending[rna]`, `pend_b = pending[rnb]`, combinational. Register 0 always reads 0.
- Ordering between a pipeline write and a pending mul/div write to the same register is the hazard unit's responsibility. This block does not reorder or check it.

## Timing
- Reset (`resetn==0` at posedge): `wb_we=0`, `wb_wn=0`, `wb_d=0`, FIFO empty, pointers 0, `pending=0`. `m_ready=0` and `pend_a/pend_b=0` while `resetn` is low.
- A reset mid-drain discards FIFO contents and pending bits. Results accepted before the reset are never written.
- Pipeline latency: `p_*` sampled at edge N appear on `wb_*` after edge N. The register file commits them on the following negedge, inside the same cycle.
- Mul/div latency: push at edge N, earliest pop at edge N+1, `wb_*` valid after edge N+1. Each pipeline-write cycle adds one cycle of delay.
- Pending bit set by issue at edge N is visible on `pend_*` after edge N. It clears after the edge that drives the result to `wb_*`.
- Sustained pipeline writes starve the FIFO indefinitely. Upstream throttles through `m_ready`, with no loss.

## Test plan
- Reset, then `p_we=1,p_wn=5,p_d=0x1234` for one cycle → next cycle `wb_we=1,wb_wn=5,wb_d=0x1234`; following cycle `wb_we=0`.
- `issue_valid,issue_wn=8`; 3 cycles later `m_valid,m_wn=8,m_d=0xCAFE` with pipeline idle → `pend_a=1` for `rna=8` from issue+1 until the write. Write `wb_wn=8,wb_d=0xCAFE` appears one cycle after the push; `pend_a=0` after it.
- Pipeline writes every cycle for 6 cycles while mul/div offers 3 results → 2 accepted, `m_ready=0` with 1 held. After pipeline stops, drains in order on 3 consecutive cycles. Pipeline data is never displaced.
- Push and pop on the same cycle with count=1 → count stays 1. Pointer wrap over 10 results is verified by in-order data.
- `p_wn=0,p_we=1` with FIFO holding `r3` → `r3` is written that cycle. `m_wn=0` push → accepted, never written.
- Assert `resetn=0` for one cycle with FIFO full and pending bits set → all outputs 0, `m_ready=0` during reset and 1 after, no stale write emitted.
